// File: rtl/param_fifo_pkg.sv
// Shared FIFO definitions: default geometry and the count-width derivation
// used by every FIFO instance in the datapath.
package param_fifo_pkg;

    localparam int FIFO_DEF_DATA_BITS = 10;
    localparam int FIFO_DEF_ADDR_BITS = 3;

    // Count/pointer width: one phase bit above the RAM address bits so that
    // 0..DEPTH can be represented and full/empty can be told apart.
    function automatic int fifo_cnt_bits(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: synchronous write port, registered read port with
// read enable. The array itself is never reset; only the read register is.
module fifo_dpram
    import param_fifo_pkg::*;
#(
    parameter int DATA_BITS = FIFO_DEF_DATA_BITS,
    parameter int ADDR_BITS = FIFO_DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 rd_en,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic [DATA_BITS-1:0] rd_data
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    logic [DATA_BITS-1:0] mem_r [DEPTH];

    // Store the write word at the write address.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Registered read: capture the addressed word when enabled, else hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= {DATA_BITS{1'b0}};
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with phase-extended pointers, registered read
// port with valid strobe, programmable almost-full/almost-empty thresholds,
// live fill level and sticky overflow/underflow flags.
module param_fifo
    import param_fifo_pkg::*;
#(
    parameter int DATA_BITS = FIFO_DEF_DATA_BITS,
    parameter int ADDR_BITS = FIFO_DEF_ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 write,
    input  logic [DATA_BITS-1:0] fifo_data_in,
    input  logic                 read,
    output logic [DATA_BITS-1:0] fifo_data_out,
    output logic                 read_valid,
    input  logic [ADDR_BITS:0]   high_limit,
    input  logic [ADDR_BITS:0]   low_limit,
    output logic                 fifo_full_out,
    output logic                 fifo_empty_out,
    output logic                 almost_full,
    output logic                 almost_empty,
    output logic [ADDR_BITS:0]   fill_level,
    output logic                 overflow_err,
    output logic                 underflow_err,
    input  logic                 err_clr
);

    // Port widths above are written as [ADDR_BITS:0], which equals CNT_BITS.
    localparam int CNT_BITS = fifo_cnt_bits(ADDR_BITS);
    localparam logic [CNT_BITS-1:0] PTR_ONE = CNT_BITS'(1);

    logic [CNT_BITS-1:0] wr_ptr_r;
    logic [CNT_BITS-1:0] rd_ptr_r;
    logic                wr_en_s;
    logic                rd_en_s;
    logic                full_s;
    logic                empty_s;

    // Status derives only from the registered pointers and the thresholds.
    assign empty_s = (wr_ptr_r == rd_ptr_r);
    assign full_s  = (wr_ptr_r[ADDR_BITS-1:0] == rd_ptr_r[ADDR_BITS-1:0]) &&
                     (wr_ptr_r[ADDR_BITS] != rd_ptr_r[ADDR_BITS]);

    assign fifo_empty_out = empty_s;
    assign fifo_full_out  = full_s;
    assign fill_level     = wr_ptr_r - rd_ptr_r;
    assign almost_full    = (fill_level >= high_limit);
    assign almost_empty   = (fill_level <= low_limit);

    // Accepted operations: rejected requests never move a pointer or the RAM.
    assign wr_en_s = write && !full_s;
    assign rd_en_s = read && !empty_s;

    // Pointer registers; natural wrap modulo 2*DEPTH through the phase bit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {CNT_BITS{1'b0}};
            rd_ptr_r <= {CNT_BITS{1'b0}};
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Valid strobe: high for exactly the cycle after an accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_en_s;
        end
    end

    // Sticky error flags; a new error in the same cycle beats err_clr.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            if (write && full_s) begin
                overflow_err <= 1'b1;
            end else if (err_clr) begin
                overflow_err <= 1'b0;
            end
            if (read && empty_s) begin
                underflow_err <= 1'b1;
            end else if (err_clr) begin
                underflow_err <= 1'b0;
            end
        end
    end

    fifo_dpram #(
        .DATA_BITS(DATA_BITS),
        .ADDR_BITS(ADDR_BITS)
    ) u_ram (
        .clk    (clk),
        .reset  (reset),
        .wr_en  (wr_en_s),
        .wr_addr(wr_ptr_r[ADDR_BITS-1:0]),
        .wr_data(fifo_data_in),
        .rd_en  (rd_en_s),
        .rd_addr(rd_ptr_r[ADDR_BITS-1:0]),
        .rd_data(fifo_data_out)
    );

endmodule

// File: tb/tb_param_fifo.sv
// Self-checking bench for param_fifo: directed scenarios plus randomized
// traffic, all compared against a queue-based reference model.
module tb_param_fifo;

    localparam int DW    = 10;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          err_clr;

    // Default-geometry instance
    logic          write, read;
    logic [DW-1:0] din, dout;
    logic          rv, full, empty, af, ae, ovf, unf;
    logic [3:0]    hl, ll, fill;

    // ADDR_BITS = 1 instance
    logic          write1, read1;
    logic [DW-1:0] din1, dout1;
    logic          rv1, full1, empty1, af1, ae1, ovf1, unf1;
    logic [1:0]    fill1;

    // ADDR_BITS = 5 instance
    logic          write5, read5;
    logic [DW-1:0] din5, dout5;
    logic          rv5, full5, empty5, af5, ae5, ovf5, unf5;
    logic [5:0]    fill5;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int q[$];
    int dout_m = 0;
    int rv_m   = 0;
    int ovf_m  = 0;
    int unf_m  = 0;

    always #5 clk = ~clk;

    param_fifo dut (
        .clk(clk), .reset(reset), .write(write), .fifo_data_in(din),
        .read(read), .fifo_data_out(dout), .read_valid(rv),
        .high_limit(hl), .low_limit(ll), .fifo_full_out(full),
        .fifo_empty_out(empty), .almost_full(af), .almost_empty(ae),
        .fill_level(fill), .overflow_err(ovf), .underflow_err(unf),
        .err_clr(err_clr)
    );

    param_fifo #(.DATA_BITS(DW), .ADDR_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .write(write1), .fifo_data_in(din1),
        .read(read1), .fifo_data_out(dout1), .read_valid(rv1),
        .high_limit(2'd2), .low_limit(2'd0), .fifo_full_out(full1),
        .fifo_empty_out(empty1), .almost_full(af1), .almost_empty(ae1),
        .fill_level(fill1), .overflow_err(ovf1), .underflow_err(unf1),
        .err_clr(err_clr)
    );

    param_fifo #(.DATA_BITS(DW), .ADDR_BITS(5)) dut5 (
        .clk(clk), .reset(reset), .write(write5), .fifo_data_in(din5),
        .read(read5), .fifo_data_out(dout5), .read_valid(rv5),
        .high_limit(6'd32), .low_limit(6'd0), .fifo_full_out(full5),
        .fifo_empty_out(empty5), .almost_full(af5), .almost_empty(ae5),
        .fill_level(fill5), .overflow_err(ovf5), .underflow_err(unf5),
        .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every output of the main instance with the model.
    task automatic compare_all();
        int lvl;
        lvl = q.size();
        check("fill_level", 32'(fill), 32'(lvl));
        check("full", 32'(full), 32'(lvl == DEPTH));
        check("empty", 32'(empty), 32'(lvl == 0));
        check("almost_full", 32'(af), 32'(lvl >= int'(hl)));
        check("almost_empty", 32'(ae), 32'(lvl <= int'(ll)));
        check("read_valid", 32'(rv), 32'(rv_m));
        check("data_out", 32'(dout), 32'(dout_m));
        check("overflow_err", 32'(ovf), 32'(ovf_m));
        check("underflow_err", 32'(unf), 32'(unf_m));
    endtask

    // One clock of traffic on the main instance, model step, full compare.
    task automatic cycle(input bit w, input bit r, input int d, input bit clr);
        bit was_full, was_empty;
        write   = w;
        read    = r;
        din     = DW'(d);
        err_clr = clr;
        @(posedge clk);
        was_full  = (q.size() == DEPTH);
        was_empty = (q.size() == 0);
        rv_m = 0;
        if (r && !was_empty) begin
            dout_m = q.pop_front();
            rv_m   = 1;
        end
        if (w && !was_full) q.push_back(d & ((1 << DW) - 1));
        if (w && was_full) ovf_m = 1; else if (clr) ovf_m = 0;
        if (r && was_empty) unf_m = 1; else if (clr) unf_m = 0;
        #1;
        write   = 1'b0;
        read    = 1'b0;
        err_clr = 1'b0;
        compare_all();
    endtask

    initial begin
        reset = 1'b1; err_clr = 1'b0;
        write = 1'b0; read = 1'b0; din = '0; hl = 4'd0; ll = 4'd0;
        write1 = 1'b0; read1 = 1'b0; din1 = '0;
        write5 = 1'b0; read5 = 1'b0; din5 = '0;
        tick(); tick();
        reset = 1'b0;
        #1;
        // Reset state, high_limit = 0 means almost_full asserted when empty
        compare_all();
        check("rst_af_hl0", 32'(af), 32'd1);

        // Fill 1..8 then drain, thresholds 6/2
        hl = 4'd6; ll = 4'd2;
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, i, 1'b0);
        check("full_after_8", 32'(full), 32'd1);
        for (int i = 1; i <= 8; i++) begin
            cycle(1'b0, 1'b1, 0, 1'b0);
            check("drain_order", 32'(dout), 32'(i));
        end
        check("empty_after_drain", 32'(empty), 32'd1);

        // Wrap with a standing occupancy of 3
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 16'h100 + i, 1'b0);
        for (int i = 3; i < 23; i++) begin
            cycle(1'b1, 1'b1, 16'h100 + i, 1'b0);
            check("wrap_level", 32'(fill), 32'd3);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 0, 1'b0);

        // Full with simultaneous write+read, then clear
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 16'h200 + i, 1'b0);
        hl = 4'd9;
        #1;
        check("af_hl9_full", 32'(af), 32'd0);
        hl = 4'd6;
        cycle(1'b1, 1'b1, 16'h3ff, 1'b0);
        check("full_wr_rd_data", 32'(dout), 32'h200);
        check("full_wr_rd_ovf", 32'(ovf), 32'd1);
        check("full_wr_rd_lvl", 32'(fill), 32'd7);
        cycle(1'b0, 1'b0, 0, 1'b1);
        check("ovf_cleared", 32'(ovf), 32'd0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1, 0, 1'b0);

        // Empty with simultaneous write+read
        cycle(1'b1, 1'b1, 16'h2a5, 1'b0);
        check("empty_wr_rd_unf", 32'(unf), 32'd1);
        check("empty_wr_rd_rv", 32'(rv), 32'd0);
        check("empty_wr_rd_lvl", 32'(fill), 32'd1);
        cycle(1'b0, 1'b1, 0, 1'b0);
        check("empty_wr_rd_data", 32'(dout), 32'h2a5);
        // Clear and new error in the same cycle: set wins
        cycle(1'b0, 1'b1, 0, 1'b1);
        check("set_wins", 32'(unf), 32'd1);
        cycle(1'b0, 1'b0, 0, 1'b1);

        // Asynchronous reset mid-burst at fill_level 5
        for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 16'h50 + i, 1'b0);
        cycle(1'b0, 1'b1, 0, 1'b0);
        check("pre_reset_lvl", 32'(fill), 32'd5);
        #1;
        reset = 1'b1;
        #1;
        q.delete(); dout_m = 0; rv_m = 0; ovf_m = 0; unf_m = 0;
        compare_all();
        #2;
        reset = 1'b0;
        #1;
        cycle(1'b1, 1'b0, 16'h0ab, 1'b0);
        cycle(1'b1, 1'b0, 16'h0cd, 1'b0);
        cycle(1'b0, 1'b1, 0, 1'b0);
        check("post_reset_first", 32'(dout), 32'h0ab);
        cycle(1'b0, 1'b1, 0, 1'b0);

        // Randomized traffic with drifting bias and thresholds
        for (int blk = 0; blk < 8; blk++) begin
            int wp;
            wp = (blk % 2 == 0) ? 75 : 30;
            hl = 4'($urandom_range(0, 15));
            ll = 4'($urandom_range(0, 15));
            for (int i = 0; i < 60; i++) begin
                cycle(($urandom_range(0, 99) < wp), ($urandom_range(0, 99) < (100 - wp)),
                      int'($urandom_range(0, 1023)), ($urandom_range(0, 19) == 0));
            end
        end

        // ADDR_BITS = 1: full exactly at 2, empty after 2 reads
        for (int i = 0; i < 2; i++) begin
            write1 = 1'b1; din1 = DW'(i + 1);
            tick();
            write1 = 1'b0;
            check("d1_fill", 32'(fill1), 32'(i + 1));
            check("d1_full", 32'(full1), 32'(i == 1));
        end
        for (int i = 0; i < 2; i++) begin
            read1 = 1'b1;
            tick();
            read1 = 1'b0;
            check("d1_data", 32'(dout1), 32'(i + 1));
            check("d1_empty", 32'(empty1), 32'(i == 1));
        end

        // ADDR_BITS = 5: full exactly at 32, empty after 32 reads
        for (int i = 0; i < 32; i++) begin
            write5 = 1'b1; din5 = DW'(i + 7);
            tick();
            write5 = 1'b0;
            check("d5_full", 32'(full5), 32'(i == 31));
        end
        check("d5_fill", 32'(fill5), 32'd32);
        for (int i = 0; i < 32; i++) begin
            read5 = 1'b1;
            tick();
            read5 = 1'b0;
            check("d5_data", 32'(dout5), 32'(i + 7));
            check("d5_empty", 32'(empty5), 32'(i == 31));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
